// File: rtl/frame_scan_reader_pkg.sv
// Display timing defaults, shade/colour types and the shade-to-colour mapping shared by the scan reader.
// Latency: none (types, constants and a combinational helper); no backpressure.
package frame_scan_reader_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int ADDR_W   = 19;
    localparam int CNT_W    = 10;
    localparam int SHADE_W  = 9;
    localparam int COLOUR_W = 8;

    typedef logic signed [SHADE_W-1:0] shade_t;
    typedef logic [COLOUR_W-1:0]       colour_t;
    typedef logic [CNT_W-1:0]          cnt_t;

    // Sync and blank travel together through the alignment pipeline.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

    // Mid-grey offset, then clamp the 10-bit signed sum into 0..255.
    function automatic colour_t shade_to_colour(input shade_t shade);
        logic signed [SHADE_W:0] level;
        colour_t                 result;
        level = $signed({shade[SHADE_W-1], shade}) + 10'sd128;
        if (level < 10'sd0) begin
            result = '0;
        end else if (level > 10'sd255) begin
            result = '1;
        end else begin
            result = level[COLOUR_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running h/v raster counters with raw (unaligned) sync, active and position decodes.
// Latency: decodes are combinational from the counter registers; no backpressure (advances every clk).
module vga_timing_counter
    import frame_scan_reader_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic  clk,
    input  logic  reset,
    output cnt_t  h_cnt,
    output logic  line_last,
    output logic  frame_last,
    output logic  at_origin,
    output logic  active,
    output logic  active_last,
    output sync_t sync_raw
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);
    localparam cnt_t H_VIS_L  = cnt_t'(H_ACTIVE - 1);
    localparam cnt_t V_VIS_L  = cnt_t'(V_ACTIVE - 1);
    localparam cnt_t HS_FIRST = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_FIRST = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    cnt_t h_q;
    cnt_t v_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_q <= h_q + 1'b1;
        end
    end

    always_comb begin
        h_cnt            = h_q;
        line_last        = (h_q == H_LAST);
        frame_last       = (h_q == H_LAST) && (v_q == V_LAST);
        at_origin        = (h_q == '0) && (v_q == '0);
        active           = (h_q < H_VIS) && (v_q < V_VIS);
        active_last      = (h_q == H_VIS_L) && (v_q == V_VIS_L);
        sync_raw         = SYNC_IDLE;
        sync_raw.hs_n    = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
        sync_raw.vs_n    = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
        sync_raw.blank_n = active;
    end

endmodule

// File: rtl/frame_scan_reader.sv
// Raster scanner: reads shades from a double-buffered frame store and drives VGA colour, syncs and blank.
// Latency: rd_addr combinational from the counters, pixel/sync outputs 2 clks later; no backpressure (free-running).
module frame_scan_reader
    import frame_scan_reader_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_buf,
    input  shade_t            rd_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              frame_start,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b
);

    cnt_t              h_cnt;
    logic              line_last;
    logic              frame_last;
    logic              at_origin;
    logic              active;
    logic              active_last;
    sync_t             sync_raw;
    sync_t             sync_d1;
    sync_t             sync_d2;
    logic [ADDR_W-1:0] line_base;
    colour_t           colour_q;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .h_cnt       (h_cnt),
        .line_last   (line_last),
        .frame_last  (frame_last),
        .at_origin   (at_origin),
        .active      (active),
        .active_last (active_last),
        .sync_raw    (sync_raw)
    );

    // Row base accumulates H_ACTIVE per line, so v*H_ACTIVE never needs a multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_base <= '0;
        end else if (frame_last) begin
            line_base <= '0;
        end else if (line_last) begin
            line_base <= line_base + ADDR_W'(H_ACTIVE);
        end
    end

    always_comb begin
        rd_addr = '0;
        if (active) begin
            rd_addr = line_base + ADDR_W'(h_cnt);
        end
    end

    // Flip only at the last visible pixel so the buffer is stable for a whole visible frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_buf   <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= active_last && swap_req;
            if (active_last && swap_req) begin
                rd_buf <= ~rd_buf;
            end
        end
    end

    assign frame_start = at_origin && !reset;

    // Stage 1 waits for the read data; stage 2 registers colour alongside the delayed syncs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_d1  <= SYNC_IDLE;
            sync_d2  <= SYNC_IDLE;
            colour_q <= '0;
        end else begin
            sync_d1  <= sync_raw;
            sync_d2  <= sync_d1;
            colour_q <= sync_d1.blank_n ? shade_to_colour(rd_data) : '0;
        end
    end

    assign vga_hs      = sync_d2.hs_n;
    assign vga_vs      = sync_d2.vs_n;
    assign vga_blank_n = sync_d2.blank_n;
    assign vga_r       = colour_q;
    assign vga_g       = colour_q;
    assign vga_b       = colour_q;

endmodule

// File: tb/tb_frame_scan_reader.sv
// Directed bench for frame_scan_reader; vertical extent is shortened so several frames fit in a short run.
module tb_frame_scan_reader;

    localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
    localparam int VA = 8, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int WAIT_LIMIT = 2 * FRAME;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [18:0]       rd_addr;
    logic              rd_buf;
    logic signed [8:0] rd_data = '0;
    logic              swap_req = 1'b0;
    logic              swap_ack;
    logic              frame_start;
    logic              vga_hs, vga_vs, vga_blank_n;
    logic [7:0]        vga_r, vga_g, vga_b;

    int errors = 0;
    int checks = 0;
    int mh = 0, mv = 0;
    int cyc = 0;
    int prev_fs = -1, prev_hs = -1, prev_vs = -1;
    logic hs_l = 1'b1, vs_l = 1'b1;
    int ack_cnt = 0;

    typedef struct {
        int h;
        int v;
        int shade;
        int addr;
        int level;
        int blank_n;
        int hs;
        int vs;
    } vec_t;

    vec_t vt[17];

    always #5 clk = ~clk;

    frame_scan_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_buf      (rd_buf),
        .rd_data     (rd_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference raster position: where the counters should be in the current cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mh <= 0;
            mv <= 0;
        end else if (mh == HT - 1) begin
            mh <= 0;
            mv <= (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh <= mh + 1;
        end
    end

    // Periodicity and frame_start placement, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_fs = -1;
            prev_hs = -1;
            prev_vs = -1;
            hs_l = 1'b1;
            vs_l = 1'b1;
        end else begin
            if (frame_start || (mh == 0 && mv == 0)) begin
                check("frame_start_at_origin", int'(frame_start), int'(mh == 0 && mv == 0));
            end
            if (frame_start) begin
                if (prev_fs >= 0) check("frame_start_period", cyc - prev_fs, FRAME);
                prev_fs = cyc;
            end
            if (hs_l && !vga_hs) begin
                if (prev_hs >= 0) check("hs_period", cyc - prev_hs, HT);
                prev_hs = cyc;
            end
            if (vs_l && !vga_vs) begin
                if (prev_vs >= 0) check("vs_period", cyc - prev_vs, FRAME);
                prev_vs = cyc;
            end
            hs_l = vga_hs;
            vs_l = vga_vs;
            if (swap_ack) ack_cnt++;
        end
    end

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIMIT) begin
            checks++;
            errors++;
            $display("FAIL wait_pos(%0d,%0d): timed out at (%0d,%0d)", h, v, mh, mv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_rd_buf"}, int'(rd_buf), 0);
        check({tag, "_swap_ack"}, int'(swap_ack), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_hs"}, int'(vga_hs), 1);
        check({tag, "_vs"}, int'(vga_vs), 1);
        check({tag, "_blank_n"}, int'(vga_blank_n), 0);
        check({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
    endtask

    initial begin
        //          h    v   shade  addr level blank hs vs
        vt[0]  = '{  5,  2,   20, 1285, 148, 1, 1, 1};
        vt[1]  = '{ 10,  3,  200, 1930, 255, 1, 1, 1};
        vt[2]  = '{ 20,  3, -200, 1940,   0, 1, 1, 1};
        vt[3]  = '{ 30,  3, -128, 1950,   0, 1, 1, 1};
        vt[4]  = '{ 40,  3,  127, 1960, 255, 1, 1, 1};
        vt[5]  = '{700,  3,   50,    0,   0, 0, 0, 1};
        vt[6]  = '{  0,  4,   -1, 2560, 127, 1, 1, 1};
        vt[7]  = '{655,  4,  100,    0,   0, 0, 1, 1};
        vt[8]  = '{656,  5,  100,    0,   0, 0, 0, 1};
        vt[9]  = '{751,  5,  100,    0,   0, 0, 0, 1};
        vt[10] = '{752,  6,  100,    0,   0, 0, 1, 1};
        vt[11] = '{639,  7,    0, 5119, 128, 1, 1, 1};
        vt[12] = '{100,  9,  100,    0,   0, 0, 1, 1};
        vt[13] = '{100, 10,  100,    0,   0, 0, 1, 0};
        vt[14] = '{100, 11,  100,    0,   0, 0, 1, 0};
        vt[15] = '{100, 12,  100,    0,   0, 0, 1, 1};
        vt[16] = '{500, 14,  -50,    0,   0, 0, 1, 1};

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");

        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("first_frame_start", int'(frame_start), 1);

        for (int i = 0; i < 17; i++) begin
            wait_pos(vt[i].h, vt[i].v);
            check($sformatf("rd_addr@(%0d,%0d)", vt[i].h, vt[i].v), int'(rd_addr), vt[i].addr);
            @(negedge clk);
            rd_data = 9'(vt[i].shade);
            @(negedge clk);
            check($sformatf("rgb@(%0d,%0d)", vt[i].h, vt[i].v), int'({vga_r, vga_g, vga_b}),
                  vt[i].level * 65536 + vt[i].level * 256 + vt[i].level);
            check($sformatf("blank_n@(%0d,%0d)", vt[i].h, vt[i].v), int'(vga_blank_n), vt[i].blank_n);
            check($sformatf("hs@(%0d,%0d)", vt[i].h, vt[i].v), int'(vga_hs), vt[i].hs);
            check($sformatf("vs@(%0d,%0d)", vt[i].h, vt[i].v), int'(vga_vs), vt[i].vs);
            rd_data = '0;
        end
        check("rd_buf_no_request", int'(rd_buf), 0);

        // Request raised mid-frame and held until acknowledged.
        wait_pos(300, 4);
        swap_req = 1'b1;
        wait_pos(639, 7);
        check("swap_rd_buf_before", int'(rd_buf), 0);
        check("swap_ack_before", int'(swap_ack), 0);
        @(negedge clk);
        check("swap_ack_pulse", int'(swap_ack), 1);
        check("swap_rd_buf_after", int'(rd_buf), 1);
        swap_req = 1'b0;
        @(negedge clk);
        check("swap_ack_drop", int'(swap_ack), 0);

        wait_pos(639, 7);
        @(negedge clk);
        check("noswap_ack", int'(swap_ack), 0);
        check("noswap_rd_buf", int'(rd_buf), 1);
        check("swap_ack_count", ack_cnt, 1);

        // Reset in the middle of the visible area.
        wait_pos(300, 5);
        #1 reset = 1'b1;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_frame_start", int'(frame_start), 1);
        check("rst_addr_origin", int'(rd_addr), 0);
        @(negedge clk);
        check("rst_frame_start_drop", int'(frame_start), 0);
        check("rst_addr_next", int'(rd_addr), 1);
        wait_pos(5, 2);
        check("rst_rd_addr@(5,2)", int'(rd_addr), 1285);
        repeat (FRAME) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_scan_reader.md
FRAME_SCAN_READER -- requirements
Module: frame_scan_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 SHALL have parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 SHALL have port clk  in  1  pixel clock; one clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port rd_addr  out  19  frame-buffer read address, v*H_ACTIVE+h.
REQ-008 SHALL have port rd_buf  out  1  selected frame buffer (double buffering).
REQ-009 SHALL have port rd_data  in  9  signed shade, valid exactly 1 clk after rd_addr.
REQ-010 SHALL have port swap_req  in  1  level request from the drawing side to flip buffers.
REQ-011 SHALL have port swap_ack  out  1  one-clk pulse confirming the flip.
REQ-012 SHALL have port frame_start  out  1  one-clk pulse at counter (0,0).
REQ-013 SHALL have ports vga_hs, vga_vs  out  1  each, active-low syncs.
REQ-014 SHALL have port vga_blank_n  out  1  high during visible pixels.
REQ-015 SHALL have ports vga_r, vga_g, vga_b  out  8  each, pixel colour.

Function
REQ-016 SHALL count h 0..H_TOTAL-1 (800) every clk, wrap to 0 and advance v 0..V_TOTAL-1 (525), v wraps to 0.
REQ-017 SHALL drive rd_addr = v*640+h (shift-add, no multiplier) when h<640 and v<480, else 0.
REQ-018 SHALL register colour, syncs and blank_n so outputs for counter (h,v) appear exactly 2 clks later.
REQ-019 SHALL compute colour as s = 128 + rd_data (10-bit signed), saturated to 0..255; r=g=b=s.
REQ-020 SHALL force r/g/b to 0 whenever the aligned blank_n is low, regardless of rd_data.
REQ-021 SHALL assert hs low for h in [656,751] and vs low for v in [490,491], before the 2-clk alignment.
REQ-022 SHALL sample swap_req only on the counter cycle h==639, v==479; if high, toggle rd_buf and pulse swap_ack on the next clk.
REQ-023 SHALL ignore swap_req at all other cycles; rd_buf never changes during active video.
REQ-024 SHALL keep swap_ack low when swap_req is low at the sample point; requester holds swap_req until ack.
REQ-025 SHALL pulse frame_start for the single clk where counters equal (0,0).
REQ-026 SHALL give reset priority over every other event on the same edge.

Reset
REQ-027 SHALL on reset: h=v=0, rd_buf=0, swap_ack=0, frame_start=0, vga_hs=vga_vs=1, vga_blank_n=0, r/g/b=0, pipeline cleared.
REQ-028 SHALL on reset mid-frame restart at (0,0); first frame_start in the first clk after release.

Structure
REQ-029 SHALL place timing constants and the 9-bit signed shade typedef in a shared display package.
REQ-030 SHALL isolate h/v counters and raw sync/active decode in sub-module vga_timing_counter.

Verification
REQ-031 SHALL verify: release reset, run 420000 clks -> hs period 800, vs period 420000, frame_start every 420000 clks.
REQ-032 SHALL verify: counter (5,2) issues rd_addr 1285; rd_data=+20 returned next clk -> r=g=b=148 two clks after (5,2).
REQ-033 SHALL verify: rd_data=+200 -> 255; rd_data=-200 -> 0; rd_data=-128 -> 0; rd_data=+127 -> 255.
REQ-034 SHALL verify: swap_req high from mid-frame -> rd_buf toggles and swap_ack pulses once, 1 clk after (639,479); swap_req low -> no toggle.
REQ-035 SHALL verify: rd_data=+50 during h=700 -> r/g/b=0, blank_n=0, rd_addr=0.
REQ-036 SHALL verify: reset asserted at (300,200) -> outputs at reset values immediately; after release counters resume at (0,0).
